// File: rtl/and_gate_arbiter.sv
// and_gate_arbiter: round-robin sequencer that shares one combinational and_gate among NUM_REQ requesters
module and_gate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic [WIDTH-1:0]         gate_a,
  output logic [WIDTH-1:0]         gate_b,
  input  logic [WIDTH-1:0]         gate_y
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] ptr, sel;
  logic sel_valid;
  logic [NUM_REQ-1:0] ptr_oh;
  assign ptr_oh = NUM_REQ'(1) << ptr;
  // rotating-priority search starting just after the last granted requester
  always_comb begin
    sel = ptr;
    sel_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_valid && req[(int'(ptr) + k) % NUM_REQ]) begin
        sel = IW'((int'(ptr) + k) % NUM_REQ);
        sel_valid = 1'b1;
      end
    end
  end
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    state <= !rst_n ? IDLE : state_nxt;
  end
  // next state and decoded pulses; ptr names the owner once a grant is made
  always_comb begin
    state_nxt = state == IDLE ? (sel_valid ? DRIVE : IDLE) : state == DRIVE ? RESP : IDLE;
    gnt = state == DRIVE ? ptr_oh : '0;
    done = state == RESP ? ptr_oh : '0;
    busy = state != IDLE;
  end
  // operand latch and pointer update on grant, result capture in DRIVE, operand clear after RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IW'(NUM_REQ - 1);
      gate_a <= '0;
      gate_b <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && sel_valid) begin
        ptr <= sel;
        gate_a <= req_a[int'(sel)*WIDTH +: WIDTH];
        gate_b <= req_b[int'(sel)*WIDTH +: WIDTH];
      end
      if (state == DRIVE) result <= gate_y;
      if (state == RESP) begin
        gate_a <= '0;
        gate_b <= '0;
      end
    end
  end
endmodule
